// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request per strobe, no backpressure; the response arrives a variable number of cycles later.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRdData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRdData
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight, and feeds decode
// through a single output slot backed by a 1-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                AnyStall,
  input  logic                Jump_IDM1,
  input  logic [25:0]         JumpTgt_IDM1,
  input  logic                BrTaken_EX,
  input  logic [31:0]         BrTgt_EX,
  fetch_stage_if.master       imem,
  output logic [31:0]         FetchData_IF,
  output logic                FetchValid_IF,
  output logic [31:0]         Pc_IF,
  output logic [31:0]         PcPlus4_IF
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e      state_q, state_d, rst_state;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        slot_v_q, slot_v_d;
  logic [31:0] slot_data_q, slot_data_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic redir_b, redir_j, redir, free;
  logic live_ack, live, imem_req;

  always_comb begin
    FetchValid_IF = slot_v_q;
    FetchData_IF  = slot_v_q ? slot_data_q : NOP_INSTR;
    Pc_IF         = slot_pc_q;
    PcPlus4_IF    = slot_pc_q + 32'd4;
  end

  always_comb begin
    redir_b  = BrTaken_EX;
    redir_j  = Jump_IDM1 & slot_v_q & ~AnyStall & ~BrTaken_EX;
    redir    = redir_b | redir_j;
    free     = ~slot_v_q | ~AnyStall;
    live_ack = imem.ImemAck & (state_q == StWait);
    live     = live_ack & ~redir;
    // A new request may go out in the same cycle the previous response lands.
    imem_req = reset_n & ~skid_v_q &
               ((state_q == StIdle) | (imem.ImemAck & ((state_q == StDrop) | free)));
  end

  assign imem.ImemReq  = imem_req;
  assign imem.ImemAddr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_addr_d = out_addr_q;
    if (redir_b) begin
      fetch_pc_d = BrTgt_EX;
    end else if (redir_j) begin
      fetch_pc_d = {PcPlus4_IF[31:28], JumpTgt_IDM1, 2'b00};
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_req) begin
      out_addr_d = fetch_pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((imem_req & redir) | ((state_q == StWait) & ~imem.ImemAck & redir)) begin
      state_d = StDrop;
    end else if (imem_req) begin
      state_d = StWait;
    end else if (imem.ImemAck) begin
      state_d = StIdle;
    end
    // A request still in flight across reset must have its response thrown away.
    rst_state = StIdle;
    if ((state_q != StIdle) & ~imem.ImemAck) begin
      rst_state = StDrop;
    end
  end

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_data_d = slot_data_q;
    slot_pc_d   = slot_pc_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (redir) begin
      slot_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (free && skid_v_q) begin
      slot_v_d    = 1'b1;
      slot_data_d = skid_data_q;
      slot_pc_d   = skid_pc_q;
      skid_v_d    = 1'b0;
    end else if (free) begin
      slot_v_d = live;
      if (live) begin
        slot_data_d = imem.ImemRdData;
        slot_pc_d   = out_addr_q;
      end
    end else if (live) begin
      skid_v_d    = 1'b1;
      skid_data_d = imem.ImemRdData;
      skid_pc_d   = out_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= rst_state;
      fetch_pc_q  <= RESET_PC;
      out_addr_q  <= RESET_PC;
      slot_v_q    <= 1'b0;
      slot_data_q <= NOP_INSTR;
      slot_pc_q   <= 32'h0000_0000;
      skid_v_q    <= 1'b0;
      skid_data_q <= NOP_INSTR;
      skid_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_addr_q  <= out_addr_d;
      slot_v_q    <= slot_v_d;
      slot_data_q <= slot_data_d;
      slot_pc_q   <= slot_pc_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

endmodule
